// File: rtl/enc_pkg.sv
// Shared definitions for the debounced 4-to-2 priority encoder.
//   state_t   : debounce FSM states (IDLE, SETTLE, ACTIVE, RELEASE)
//   ENC_IN_W  : width of the raw request vector (4)
//   ENC_OUT_W : width of the encoded index (2)
//   prio4()   : highest-set-bit index of a 4-bit vector, A[3] wins
package enc_pkg;

  localparam int ENC_IN_W  = 4;
  localparam int ENC_OUT_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // All-zero input maps to 0; callers only use the result for non-zero input.
  function automatic logic [ENC_OUT_W-1:0] prio4(input logic [ENC_IN_W-1:0] a);
    logic [ENC_OUT_W-1:0] r;
    casez (a)
      4'b1???: r = 2'd3;
      4'b01??: r = 2'd2;
      4'b001?: r = 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/input_sync.sv
// Multi-flop synchronizer for the raw 4-bit request vector.
//   clk : system clock
//   rst : asynchronous active-high reset, clears every stage
//   d   : raw asynchronous input
//   q   : d delayed by SYNC_STAGES flops
module input_sync
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ENC_IN_W-1:0] d,
  output logic [ENC_IN_W-1:0] q
);

  logic [SYNC_STAGES-1:0][ENC_IN_W-1:0] chain_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_p0 <= '0;
    end else begin
      chain_p0 <= {chain_p0[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_p0[SYNC_STAGES-1];

endmodule

// File: rtl/encoder42_debounced.sv
// Debounced sequential 4-to-2 priority encoder for board switches/buttons.
// The raw vector is synchronized, debounced by a four-state FSM, and the
// highest active bit of the accepted value is presented as a 2-bit code.
//   clk    : system clock, all state on rising edge
//   rst    : asynchronous active-high reset
//   A      : raw request lines, A[3] highest priority
//   Y      : encoded index of the accepted request (holds after release)
//   valid  : high while an accepted non-zero input is held
//   strobe : one-cycle pulse when Y/valid take a newly accepted code
//   multi  : (only with ENC_MULTI_ERR_EN defined) accepted value had more
//            than one bit set; updated on each strobe, cleared when valid falls
module encoder42_debounced
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ENC_IN_W-1:0]  A,
  output logic [ENC_OUT_W-1:0] Y,
  output logic                 valid,
  output logic                 strobe
`ifdef ENC_MULTI_ERR_EN
  ,
  output logic                 multi
`endif
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [ENC_IN_W-1:0] a_s;
  logic [ENC_IN_W-1:0] snap;
  logic [CNT_W-1:0]    cnt;
  state_t              state;

`ifdef ENC_MULTI_ERR_EN
  function automatic logic multi_bits(input logic [ENC_IN_W-1:0] v);
    // Clearing the lowest set bit leaves something only if two or more were set.
    return (v & (v - 1'b1)) != '0;
  endfunction
`endif

  // Stage boundary: raw pins -> synchronized a_s
  input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (A),
    .q   (a_s)
  );

  // Stage boundary: a_s -> debounce FSM with registered outputs.
  // cnt only increments when it is below CNT_LAST, so it saturates by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      snap   <= '0;
      cnt    <= '0;
      Y      <= '0;
      valid  <= 1'b0;
      strobe <= 1'b0;
`ifdef ENC_MULTI_ERR_EN
      multi  <= 1'b0;
`endif
    end else begin
      strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (a_s != '0) begin
            snap  <= a_s;
            cnt   <= '0;
            state <= SETTLE;
          end
        end

        SETTLE: begin
          if (a_s == '0) begin
            // valid is only set here if we arrived from ACTIVE/RELEASE; in that
            // case the drop counts as the start of a release, not an abort.
            cnt   <= '0;
            state <= valid ? RELEASE : IDLE;
          end else if (a_s != snap) begin
            snap <= a_s;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            Y      <= prio4(snap);
            valid  <= 1'b1;
            strobe <= 1'b1;
`ifdef ENC_MULTI_ERR_EN
            multi  <= multi_bits(snap);
`endif
            state  <= ACTIVE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ACTIVE: begin
          if (a_s == '0) begin
            cnt   <= '0;
            state <= RELEASE;
          end else if (a_s != snap) begin
            snap  <= a_s;
            cnt   <= '0;
            state <= SETTLE;
          end
        end

        RELEASE: begin
          if (a_s == '0) begin
            if (cnt == CNT_LAST) begin
              valid <= 1'b0;
`ifdef ENC_MULTI_ERR_EN
              multi <= 1'b0;
`endif
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (a_s == snap) begin
            // Input bounced back to the held value: keep it, no new strobe.
            state <= ACTIVE;
          end else begin
            snap  <= a_s;
            cnt   <= '0;
            state <= SETTLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder42_debounced.sv
module tb_encoder42_debounced;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int DB16 = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A;
  logic [1:0] Y;
  logic       valid;
  logic       strobe;
  logic [3:0] A16;
  logic [1:0] Y16;
  logic       valid16;
  logic       strobe16;
`ifdef ENC_MULTI_ERR_EN
  logic       multi;
  logic       multi16;
`endif

  always #5 clk = ~clk;

  encoder42_debounced #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .Y      (Y),
    .valid  (valid),
    .strobe (strobe)
`ifdef ENC_MULTI_ERR_EN
    ,
    .multi  (multi)
`endif
  );

  encoder42_debounced #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB16)) dut16 (
    .clk    (clk),
    .rst    (rst),
    .A      (A16),
    .Y      (Y16),
    .valid  (valid16),
    .strobe (strobe16)
`ifdef ENC_MULTI_ERR_EN
    ,
    .multi  (multi16)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model (operates on run lengths) -------------
  typedef struct {
    logic [1:0] y;
`ifdef ENC_MULTI_ERR_EN
    logic       multi;
`endif
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] line_q[$];
  int         cyc;
  logic       m_valid, m_strobe;
  logic [1:0] m_y;
`ifdef ENC_MULTI_ERR_EN
  logic       m_multi;
`endif
  logic [3:0] m_last;   // most recent non-zero synchronized sample
  int         m_nrun;   // length of current run of m_last while a candidate is pending
  int         m_zrun;   // length of current run of zeros
  logic       m_pend;   // a candidate value is being timed for acceptance

  function automatic logic [1:0] prio_ref(input logic [3:0] v);
    logic [1:0] r = 2'd0;
    for (int b = 0; b < 4; b++) if (v[b]) r = 2'(b);
    return r;
  endfunction

  task automatic model_reset();
    line_q.delete();
    for (int i = 0; i < SYNC; i++) line_q.push_back(4'd0);
    exp_q.delete();
    m_valid = 1'b0; m_strobe = 1'b0; m_y = 2'd0;
`ifdef ENC_MULTI_ERR_EN
    m_multi = 1'b0;
`endif
    m_last = 4'd0; m_nrun = 0; m_zrun = 1; m_pend = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] s);
    exp_t e;
    m_strobe = 1'b0;
    if (s == 4'd0) begin
      m_pend = 1'b0;
      m_nrun = 0;
      if (m_zrun < 100000) m_zrun++;
      // A release needs DB+1 consecutive zero samples, like a press.
      if (m_valid && m_zrun == DB + 1) begin
        m_valid = 1'b0;
`ifdef ENC_MULTI_ERR_EN
        m_multi = 1'b0;
`endif
      end
    end else begin
      if (s != m_last || (m_zrun > 0 && !m_valid)) begin
        m_last = s; m_nrun = 1; m_pend = 1'b1;
      end else if (m_pend) begin
        m_nrun++;
      end
      m_zrun = 0;
      if (m_pend && m_nrun == DB + 1) begin
        m_pend = 1'b0;
        m_valid = 1'b1;
        m_strobe = 1'b1;
        m_y = prio_ref(s);
        e.y = m_y;
`ifdef ENC_MULTI_ERR_EN
        m_multi = ($countones(s) > 1);
        e.multi = m_multi;
`endif
        e.cyc = cyc;
        exp_q.push_back(e);
      end
    end
  endtask

  initial begin
    logic [3:0] s;
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        cyc++;
        line_q.push_back(A);
        s = line_q.pop_front();
        model_step(s);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("valid", int'(valid), int'(m_valid));
      check("Y", int'(Y), int'(m_y));
      check("strobe", int'(strobe), int'(m_strobe));
      if (strobe) begin
        if (exp_q.size() == 0) check("sb_unexpected_strobe", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sb_y", int'(Y), int'(e.y));
          check("sb_cycle", cyc, e.cyc);
`ifdef ENC_MULTI_ERR_EN
          check("sb_multi", int'(multi), int'(e.multi));
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  // Called at a negedge: drive v for n cycles, counting strobes and valid lows.
  task automatic run(input logic [3:0] v, input int n, output int sc, output int vlow);
    A = v; sc = 0; vlow = 0;
    repeat (n) begin
      @(negedge clk);
      if (strobe) sc++;
      if (!valid) vlow++;
    end
  endtask

  // Drive v and count edges until strobe (or valid falls when want_fall).
  task automatic latency(input logic [3:0] v, input logic want_fall, output int edges, output int sc);
    A = v; edges = 0; sc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (strobe) sc++;
      edges = i;
      if (!want_fall && strobe) break;
      if (want_fall && !valid) break;
    end
  endtask

  initial begin
    int sc, sc2, vl, vl2, ed;
    rst = 1'b1; A = 4'd0; A16 = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_Y", int'(Y), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_strobe", int'(strobe), 0);
    rst = 1'b0;
    run(4'd0, 3, sc, vl);

    // Clean press and release
    latency(4'b0010, 1'b0, ed, sc);
    check("press_latency", ed, SYNC + DB + 1);
    check("press_Y", int'(Y), 1);
    check("press_valid", int'(valid), 1);
    run(4'b0010, 5, sc, vl);
    check("press_hold_strobes", sc, 0);
    latency(4'b0000, 1'b1, ed, sc);
    check("release_latency", ed, SYNC + DB + 1);
    check("release_strobes", sc, 0);
    check("release_Y_held", int'(Y), 1);
    run(4'd0, 4, sc, vl);

    // Bounce: toggle every 2 cycles for 12 cycles, then hold
    sc2 = 0;
    for (int i = 0; i < 3; i++) begin
      run(4'b0100, 2, sc, vl); sc2 += sc;
      run(4'b0000, 2, sc, vl); sc2 += sc;
    end
    check("bounce_no_strobe", sc2, 0);
    run(4'b0100, 15, sc, vl);
    check("bounce_one_strobe", sc, 1);
    check("bounce_Y", int'(Y), 2);

    // Priority and code change without release
    run(4'b1011, 12, sc, vl);
    check("prio_strobe", sc, 1);
    check("prio_Y", int'(Y), 3);
`ifdef ENC_MULTI_ERR_EN
    check("prio_multi", int'(multi), 1);
`endif
    run(4'b0001, 12, sc, vl);
    check("change_strobe", sc, 1);
    check("change_valid_low", vl, 0);
    check("change_Y", int'(Y), 0);
`ifdef ENC_MULTI_ERR_EN
    check("change_multi", int'(multi), 0);
`endif

    // Release glitch while holding 1000
    run(4'b1000, 12, sc, vl);
    check("glitch_pre_strobe", sc, 1);
    run(4'b0000, 2, sc, vl);
    run(4'b1000, 12, sc2, vl2);
    check("glitch_strobes", sc + sc2, 0);
    check("glitch_valid_low", vl + vl2, 0);
    check("glitch_Y", int'(Y), 3);

    // Same-priority change 1000 -> 1001: strobe fires, Y unchanged
    run(4'b1001, 12, sc, vl);
    check("sameprio_strobe", sc, 1);
    check("sameprio_Y", int'(Y), 3);

    // Reset mid-SETTLE
    run(4'b0000, 14, sc, vl);
    run(4'b0100, 4, sc, vl);
    #2 rst = 1'b1;
    #1;
    check("midreset_Y", int'(Y), 0);
    check("midreset_valid", int'(valid), 0);
    check("midreset_strobe", int'(strobe), 0);
    @(negedge clk);
    rst = 1'b0;
    latency(4'b0100, 1'b0, ed, sc);
    check("post_reset_latency", ed, SYNC + DB + 1);
    check("post_reset_Y", int'(Y), 2);

    // Long debounce instance
    A16 = 4'b0001; ed = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      ed = i;
      if (strobe16) break;
    end
    check("long_latency", ed, SYNC + DB16 + 1);
    check("long_Y", int'(Y16), 0);
    sc = 0; vl = 0;
    repeat (100) begin
      @(negedge clk);
      if (strobe16) sc++;
      if (!valid16) vl++;
    end
    check("long_no_second_strobe", sc, 0);
    check("long_valid_held", vl, 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = 4'd0;
      run(v, int'($urandom_range(1, 9)), sc, vl);
    end
    run(4'd0, 30, sc, vl);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/encoder42_debounced.md
Name: encoder42_debounced

Overview:
- Sequential 4-to-2 priority encoder for raw board inputs (switches/buttons).
- Synchronizes and debounces a 4-bit input vector, then priority-encodes the highest active bit into a 2-bit code.
- Outputs the code with a level valid and a one-cycle strobe on each newly accepted code.
- Sits between on-board switches/buttons and downstream control logic (e.g. a 2-4 decode stage driving LEDs).

Parameters:
- SYNC_STAGES, 2: flip-flop stages in the input synchronizer; legal values ≥2.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles needed to accept a press or a release; legal values ≥2.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- A    input  4  raw active-high request lines; A[3] has highest priority.
- Y    output 2  encoded index of the highest active accepted request.
- valid  output 1  high while an accepted non-zero input is held.
- strobe output 1  one-cycle pulse when Y/valid take a newly accepted code.

Behaviour:
- Reset: Y=2'b00, valid=0, strobe=0, synchronizer=0, snapshot=0, counter=0, FSM=IDLE. Asserting rst mid-operation aborts immediately; no strobe is issued during or on exit from reset.
- Synchronizer: `a_s` is A delayed by SYNC_STAGES flops. The FSM sees only `a_s`.
- Priority function: A[3]→3, else A[2]→2, else A[1]→1, else A[0]→0. For all-zero input the encode is unused.
- FSM states: IDLE, SETTLE, ACTIVE, RELEASE.
- IDLE:
  - valid=0; Y holds its last value.
  - If a_s≠0: snapshot←a_s, cnt←0, go to SETTLE.
- SETTLE:
  - If a_s==0: go to IDLE. valid is unchanged; if entered from ACTIVE, go to RELEASE instead.
  - Else if a_s≠snapshot: snapshot←a_s, cnt←0.
  - Else if cnt==DEBOUNCE_CYCLES-1: Y←prio(snapshot), valid←1, strobe←1 for one cycle, go to ACTIVE.
  - Else cnt←cnt+1.
- ACTIVE:
  - If a_s==0: cnt←0, go to RELEASE.
  - If a_s≠snapshot and non-zero: snapshot←a_s, cnt←0, go to SETTLE. valid stays 1 and Y holds until the new code is accepted.
- RELEASE:
  - If a_s==snapshot: go to ACTIVE. This is a bounce; no strobe.
  - If a_s is another non-zero value: snapshot←a_s, cnt←0, go to SETTLE.
  - If a_s==0 and cnt==DEBOUNCE_CYCLES-1: valid←0, go to IDLE. Y holds; no strobe.
  - Else cnt←cnt+1.
- Latency: A held constant from before clock edge 0 gives strobe high after edge SYNC_STAGES+DEBOUNCE_CYCLES+1. Release latency to valid=0 is the same.
- Accepted-code change without release (e.g. 0001→0100 held): exactly one new strobe.
  - If the new snapshot gives the same prio as the current Y (e.g. 1000→1001), Y is unchanged and strobe still fires.
- Counter width: clog2(DEBOUNCE_CYCLES). It saturates and never wraps.
- strobe and valid are registered outputs; there are no combinational paths from A.

Optional Feature:
- Macro: ENC_MULTI_ERR_EN.
- Defined:
  - Adds output port `multi` (1 bit, reset 0).
  - On every strobe, multi←1 if the accepted snapshot has more than one bit set, else multi←0.
  - multi holds between strobes and clears when valid falls.
- Undefined: no multi port and no popcount logic; all other behaviour is identical.

Decomposition:
- Package enc_pkg holds:
  - the state typedef (IDLE, SETTLE, ACTIVE, RELEASE);
  - constants ENC_IN_W=4 and ENC_OUT_W=2;
  - function prio4(input [3:0]) returning [1:0].
- Sub-module input_sync: parameterized SYNC_STAGES × width-4 flop chain with async active-high reset, instantiated once.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless noted):
- Reset: rst high mid-SETTLE with A=0100 → Y=00, valid=0, strobe=0 immediately. After rst falls with A held, strobe follows 7 edges later with Y=10.
- Clean press: A 0000→0010 held → strobe one cycle after edge 7, Y=01, valid=1. Release → valid=0 after 7 edges, no strobe, Y stays 01.
- Bounce: A toggles 0100/0000 every 2 cycles for 12 cycles, then holds 0100 → no strobe during toggling; exactly one strobe, Y=10.
- Priority: A=1011 held → Y=11. With ENC_MULTI_ERR_EN, multi=1. Then A=0001 → new strobe, Y=00, multi=0, valid stays 1 throughout.
- Release glitch: in ACTIVE with A=1000, drop to 0000 for 2 cycles then back → valid stays 1, no strobe, Y=11.
- Long debounce (DEBOUNCE_CYCLES=16): A=0001 held → strobe after exactly edge 19. Counter saturates, no spurious second strobe over 100 further cycles.
